// File: rtl/cv32e40px_apu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cv32e40px_apu_pkg
// Brief   : Shared types and defaults for the APU writeback buffer.
// Revision: 1.0 - initial release
// ============================================================================
package cv32e40px_apu_pkg;

  localparam int APU_WB_DEPTH    = 2;
  localparam int APU_OUTSTANDING = 2;
  localparam int APU_DATA_WIDTH  = 32;
  localparam int APU_ADDR_WIDTH  = 6;
  localparam int APU_FLAGS_WIDTH = 5;

  typedef struct packed {
    logic [APU_ADDR_WIDTH-1:0]  waddr;
    logic [APU_DATA_WIDTH-1:0]  data;
    logic [APU_FLAGS_WIDTH-1:0] flags;
  } apu_wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/cv32e40px_apu_wb_buffer_if.sv
`default_nettype none
// ============================================================================
// Module  : cv32e40px_apu_wb_buffer_if
// Brief   : APU result input and shared regfile write port of the wb buffer.
// Revision: 1.0 - initial release
// ============================================================================
interface cv32e40px_apu_wb_buffer_if
  import cv32e40px_apu_pkg::*;
#(
  parameter int DATA_WIDTH  = APU_DATA_WIDTH,
  parameter int ADDR_WIDTH  = APU_ADDR_WIDTH,
  parameter int FLAGS_WIDTH = APU_FLAGS_WIDTH
);

  logic                   apu_rvalid;
  logic [DATA_WIDTH-1:0]  apu_result;
  logic [FLAGS_WIDTH-1:0] apu_flags;
  logic [ADDR_WIDTH-1:0]  apu_waddr;
  logic                   port_busy;
  logic                   regfile_we;
  logic [ADDR_WIDTH-1:0]  regfile_waddr;
  logic [DATA_WIDTH-1:0]  regfile_wdata;
  logic                   fflags_we;
  logic [FLAGS_WIDTH-1:0] fflags;

  // master: APU result source plus core writeback arbitration
  modport master (
    output apu_rvalid, apu_result, apu_flags, apu_waddr, port_busy,
    input  regfile_we, regfile_waddr, regfile_wdata, fflags_we, fflags
  );

  modport slave (
    input  apu_rvalid, apu_result, apu_flags, apu_waddr, port_busy,
    output regfile_we, regfile_waddr, regfile_wdata, fflags_we, fflags
  );

endinterface
`default_nettype wire

// File: rtl/cv32e40px_apu_wb_fifo.sv
`default_nettype none
// ============================================================================
// Module  : cv32e40px_apu_wb_fifo
// Brief   : In-order result store with pointers, occupancy and valid vector.
// Revision: 1.0 - initial release
// ============================================================================
module cv32e40px_apu_wb_fifo
  import cv32e40px_apu_pkg::*;
#(
  parameter int  DEPTH = APU_WB_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                push_i,
  input  logic                pop_i,
  input  apu_wb_entry_t       wdata_i,
  output apu_wb_entry_t       rdata_o,
  output apu_wb_entry_t       entries_o [DEPTH],
  output logic [DEPTH-1:0]    valid_o,
  output logic [CNT_W-1:0]    count_o,
  output logic                full_o,
  output logic                empty_o
);

  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic [DEPTH-1:0] r_valid;
  apu_wb_entry_t    r_mem [DEPTH];

  logic w_push;
  logic w_pop;

  assign full_o  = (r_count == CNT_W'(DEPTH));
  assign empty_o = (r_count == '0);
  assign w_pop   = pop_i & ~empty_o;
  assign w_push  = push_i & (~full_o | w_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_valid  <= '0;
    end else begin
      if (w_pop) begin
        r_rd_ptr          <= r_rd_ptr + 1'b1;
        r_valid[r_rd_ptr] <= 1'b0;
      end
      // A full push+pop targets the slot being freed; the later set wins.
      if (w_push) begin
        r_wr_ptr          <= r_wr_ptr + 1'b1;
        r_valid[r_wr_ptr] <= 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wdata_i;
    end
  end

  assign rdata_o   = r_mem[r_rd_ptr];
  assign entries_o = r_mem;
  assign valid_o   = r_valid;
  assign count_o   = r_count;

endmodule
`default_nettype wire

// File: rtl/cv32e40px_apu_wb_buffer.sv
`default_nettype none
// ============================================================================
// Module  : cv32e40px_apu_wb_buffer
// Brief   : Merges APU results into the core regfile write port, buffering
//           them when the core owns the port, and flags hazards on them.
// Revision: 1.0 - initial release
// ============================================================================
module cv32e40px_apu_wb_buffer
  import cv32e40px_apu_pkg::*;
#(
  parameter int DEPTH       = APU_WB_DEPTH,
  parameter int DATA_WIDTH  = APU_DATA_WIDTH,
  parameter int ADDR_WIDTH  = APU_ADDR_WIDTH,
  parameter int FLAGS_WIDTH = APU_FLAGS_WIDTH,
  parameter int OUTSTANDING = APU_OUTSTANDING
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  cv32e40px_apu_wb_buffer_if.slave    bus,
  input  logic [2:0][ADDR_WIDTH-1:0]  read_regs_i,
  input  logic [2:0]                  read_regs_valid_i,
  input  logic [ADDR_WIDTH-1:0]       write_reg_i,
  input  logic                        write_reg_valid_i,
  output logic                        dep_o,
  output logic                        issue_block_o,
  output logic                        empty_o,
  output logic                        overflow_o
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  localparam logic [ADDR_WIDTH-1:0]  c_addr_zero  = '0;
  localparam logic [DATA_WIDTH-1:0]  c_data_zero  = '0;
  localparam logic [FLAGS_WIDTH-1:0] c_flags_zero = '0;

  apu_wb_entry_t    w_in;
  apu_wb_entry_t    w_head;
  apu_wb_entry_t    w_entries [DEPTH];
  logic [DEPTH-1:0] w_valid;
  logic [CNT_W-1:0] w_count;
  logic             w_full;
  logic             w_empty;
  logic             w_bypass;
  logic             w_drain;
  logic             w_push;
  logic             w_drop;
  logic             w_dep;
  logic             r_overflow;

  assign w_in.waddr = bus.apu_waddr;
  assign w_in.data  = bus.apu_result;
  assign w_in.flags = bus.apu_flags;

  // Buffered entries always take the port before a new result, keeping order.
  assign w_bypass = w_empty & bus.apu_rvalid & ~bus.port_busy;
  assign w_drain  = ~w_empty & ~bus.port_busy;
  assign w_push   = bus.apu_rvalid & ~w_bypass & (~w_full | w_drain);
  assign w_drop   = bus.apu_rvalid & w_full & ~w_drain;

  cv32e40px_apu_wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push_i    (w_push),
    .pop_i     (w_drain),
    .wdata_i   (w_in),
    .rdata_o   (w_head),
    .entries_o (w_entries),
    .valid_o   (w_valid),
    .count_o   (w_count),
    .full_o    (w_full),
    .empty_o   (w_empty)
  );

  assign bus.regfile_we    = w_drain | w_bypass;
  assign bus.fflags_we     = w_drain | w_bypass;
  assign bus.regfile_waddr = w_drain  ? w_head.waddr :
                             w_bypass ? bus.apu_waddr : c_addr_zero;
  assign bus.regfile_wdata = w_drain  ? w_head.data :
                             w_bypass ? bus.apu_result : c_data_zero;
  assign bus.fflags        = w_drain  ? w_head.flags :
                             w_bypass ? bus.apu_flags : c_flags_zero;

  // Entry being popped this cycle is still compared; the valid vector is registered.
  always_comb begin
    w_dep = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_valid[i]) begin
        for (int j = 0; j < 3; j++) begin
          if (read_regs_valid_i[j] && (read_regs_i[j] == w_entries[i].waddr)) begin
            w_dep = 1'b1;
          end
        end
        if (write_reg_valid_i && (write_reg_i == w_entries[i].waddr)) begin
          w_dep = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end
  end

  assign dep_o         = w_dep;
  assign issue_block_o = (DEPTH - int'(w_count)) < OUTSTANDING;
  assign empty_o       = w_empty;
  assign overflow_o    = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_cv32e40px_apu_wb_buffer.sv
`default_nettype none
// ============================================================================
// Module  : tb_cv32e40px_apu_wb_buffer
// Brief   : Directed self-checking bench with an in-order write scoreboard.
// Revision: 1.0 - initial release
// ============================================================================
module tb_cv32e40px_apu_wb_buffer;
  import cv32e40px_apu_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic [2:0][5:0] read_regs;
  logic [2:0]      read_regs_valid;
  logic [5:0]      write_reg;
  logic            write_reg_valid;
  logic            dep;
  logic            issue_block;
  logic            empty;
  logic            overflow;

  cv32e40px_apu_wb_buffer_if bus ();

  cv32e40px_apu_wb_buffer dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .bus               (bus),
    .read_regs_i       (read_regs),
    .read_regs_valid_i (read_regs_valid),
    .write_reg_i       (write_reg),
    .write_reg_valid_i (write_reg_valid),
    .dep_o             (dep),
    .issue_block_o     (issue_block),
    .empty_o           (empty),
    .overflow_o        (overflow)
  );

  always #5 clk = ~clk;

  int            vectors     = 0;
  int            miscompares = 0;
  apu_wb_entry_t sb[$];
  bit            mon_en      = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    @(negedge clk);
  endtask

  task automatic result(input logic [5:0] a, input logic [31:0] d, input logic [4:0] f,
                        input bit expect_write);
    bus.apu_rvalid = 1'b1;
    bus.apu_waddr  = a;
    bus.apu_result = d;
    bus.apu_flags  = f;
    if (expect_write) sb.push_back('{waddr: a, data: d, flags: f});
  endtask

  task automatic no_result;
    bus.apu_rvalid = 1'b0;
    bus.apu_waddr  = '0;
    bus.apu_result = '0;
    bus.apu_flags  = '0;
  endtask

  // Scoreboard: every regfile write must match the oldest expected result.
  always @(negedge clk) begin
    if (mon_en && bus.regfile_we === 1'b1) begin
      check("we_while_busy", bus.port_busy, 1'b0);
      check("fflags_we", bus.fflags_we, 1'b1);
      if (sb.size() == 0) begin
        check("spurious_write", bus.regfile_we, 1'b0);
      end else begin
        apu_wb_entry_t e;
        e = sb.pop_front();
        check("sb_waddr", bus.regfile_waddr, e.waddr);
        check("sb_wdata", bus.regfile_wdata, e.data);
        check("sb_fflags", bus.fflags, e.flags);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst             = 1'b1;
    read_regs       = '0;
    read_regs_valid = '0;
    write_reg       = '0;
    write_reg_valid = 1'b0;
    bus.port_busy   = 1'b0;
    no_result();
    tick();
    tick();
    rst    = 1'b0;
    mon_en = 1'b1;

    // Reset state
    settle();
    check("rst_we", bus.regfile_we, 1'b0);
    check("rst_waddr", bus.regfile_waddr, 6'h00);
    check("rst_wdata", bus.regfile_wdata, 32'h0);
    check("rst_fflags", bus.fflags, 5'h00);
    check("rst_dep", dep, 1'b0);
    check("rst_issue_block", issue_block, 1'b0);
    check("rst_empty", empty, 1'b1);
    check("rst_overflow", overflow, 1'b0);

    // Bypass in the same cycle
    tick();
    result(6'h21, 32'hDEADBEEF, 5'h11, 1'b1);
    settle();
    check("byp_we", bus.regfile_we, 1'b1);
    check("byp_waddr", bus.regfile_waddr, 6'h21);
    check("byp_wdata", bus.regfile_wdata, 32'hDEADBEEF);
    check("byp_empty", empty, 1'b1);
    tick();
    no_result();
    settle();
    check("byp_after_empty", empty, 1'b1);
    check("byp_after_we", bus.regfile_we, 1'b0);

    // Busy port buffers two results
    tick();
    bus.port_busy = 1'b1;
    result(6'h03, 32'h1111_0003, 5'h03, 1'b1);
    tick();
    result(6'h04, 32'h1111_0004, 5'h04, 1'b1);
    tick();
    no_result();
    settle();
    check("busy_we", bus.regfile_we, 1'b0);
    check("busy_empty", empty, 1'b0);
    check("busy_issue_block", issue_block, 1'b1);
    tick();
    bus.port_busy = 1'b0;
    settle();
    check("rel_waddr0", bus.regfile_waddr, 6'h03);
    tick();
    settle();
    check("rel_waddr1", bus.regfile_waddr, 6'h04);
    tick();
    settle();
    check("rel_empty", empty, 1'b1);
    check("rel_we", bus.regfile_we, 1'b0);

    // Ordering: buffered entry wins over the incoming result
    tick();
    bus.port_busy = 1'b1;
    result(6'h05, 32'h2222_0005, 5'h05, 1'b1);
    tick();
    bus.port_busy   = 1'b0;
    result(6'h06, 32'h2222_0006, 5'h06, 1'b1);
    read_regs[2]    = 6'h05;
    read_regs_valid = 3'b100;
    settle();
    check("ord_waddr0", bus.regfile_waddr, 6'h05);
    check("ord_dep_popping", dep, 1'b1);
    tick();
    no_result();
    read_regs_valid = 3'b000;
    settle();
    check("ord_waddr1", bus.regfile_waddr, 6'h06);
    tick();
    settle();
    check("ord_empty", empty, 1'b1);

    // Full push+pop keeps count at DEPTH
    tick();
    bus.port_busy = 1'b1;
    result(6'h07, 32'h3333_0007, 5'h07, 1'b1);
    tick();
    result(6'h08, 32'h3333_0008, 5'h08, 1'b1);
    tick();
    bus.port_busy = 1'b0;
    result(6'h09, 32'h3333_0009, 5'h09, 1'b1);
    settle();
    check("full_waddr0", bus.regfile_waddr, 6'h07);
    check("full_overflow", overflow, 1'b0);
    tick();
    no_result();
    settle();
    check("full_waddr1", bus.regfile_waddr, 6'h08);
    check("full_still_busy", issue_block, 1'b1);
    tick();
    settle();
    check("full_waddr2", bus.regfile_waddr, 6'h09);
    tick();
    settle();
    check("full_empty", empty, 1'b1);
    check("full_issue_clear", issue_block, 1'b0);
    check("full_overflow_end", overflow, 1'b0);

    // Hazard detection on a buffered destination
    tick();
    bus.port_busy = 1'b1;
    result(6'h0A, 32'h4444_000A, 5'h0A, 1'b1);
    tick();
    no_result();
    read_regs[1]    = 6'h0A;
    read_regs_valid = 3'b010;
    settle();
    check("haz_read_valid", dep, 1'b1);
    tick();
    read_regs_valid = 3'b000;
    settle();
    check("haz_read_invalid", dep, 1'b0);
    tick();
    write_reg       = 6'h0A;
    write_reg_valid = 1'b1;
    settle();
    check("haz_write_valid", dep, 1'b1);
    tick();
    write_reg_valid = 1'b0;
    read_regs[0]    = 6'h0B;
    read_regs_valid = 3'b001;
    settle();
    check("haz_no_match", dep, 1'b0);

    // Overflow: full and blocked, result dropped
    tick();
    read_regs_valid = 3'b000;
    result(6'h0C, 32'h5555_000C, 5'h0C, 1'b1);
    tick();
    result(6'h0D, 32'h5555_000D, 5'h0D, 1'b0);
    settle();
    check("ovf_before", overflow, 1'b0);
    tick();
    no_result();
    settle();
    check("ovf_set", overflow, 1'b1);
    check("ovf_not_empty", empty, 1'b0);
    tick();
    settle();
    check("ovf_sticky", overflow, 1'b1);

    // Reset mid-operation discards buffered results
    tick();
    rst = 1'b1;
    sb.delete();
    tick();
    rst           = 1'b0;
    bus.port_busy = 1'b0;
    settle();
    check("mrst_empty", empty, 1'b1);
    check("mrst_we", bus.regfile_we, 1'b0);
    check("mrst_overflow", overflow, 1'b0);
    check("mrst_issue_block", issue_block, 1'b0);
    tick();
    settle();
    check("mrst_we_next", bus.regfile_we, 1'b0);
    check("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
